// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared types, opcode/funct3 constants and access helpers for the load/store sequencer.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width must exist for the access kind and the address must be naturally aligned.
    function automatic logic access_legal(input logic st, input logic [2:0] f3, input logic [1:0] al);
        logic ok_f3;
        logic ok_al;
        ok_f3 = st ? (f3 <= F3_W) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        ok_al = (f3[1:0] == 2'b10) ? (al == 2'b00) : (f3[1:0] == 2'b01) ? !al[0] : 1'b1;
        return ok_f3 && ok_al;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] al);
        return (sz == 2'b00) ? 4'b0001 << al : (sz == 2'b01) ? 4'b0011 << al : 4'b1111;
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// lsu_ctrl_load_align: selects the addressed byte/half of a read word and sign/zero-extends it.
//   rdata   - raw memory word
//   funct3  - load width/sign field
//   addr_lo - byte offset within the word
//   result  - extended 32-bit load value
module lsu_ctrl_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);
    logic [31:0] shifted;
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h0, shifted[7:0]};
            F3_HU:   result = {16'h0, shifted[15:0]};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store sequencer with memory handshake, load extension and fault pulses.
//   clock, nReset       - clock and asynchronous active-low reset
//   opcode, funct3      - decoded instruction fields (held while stall=1)
//   addr_lo             - low effective-address bits
//   mem_ready, rdata    - memory completion and read word
//   stall               - hold PC
//   mem_req/we/be       - memory request, store flag, byte enables
//   ld_wdata, ld_regw   - extended load result and one-cycle write strobe
//   fault               - one-cycle fault (illegal, misaligned or timeout)
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        mem_ready,
    input  logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] ld_wdata,
    output logic        ld_regw,
    output logic        fault
);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t      state, state_nx;
    logic [2:0]  f3_q;
    logic [1:0]  al_q;
    logic        we_q;
    logic [7:0]  cnt, cnt_nx;
    logic [31:0] data_q, aligned;
    logic        is_mem, is_st;

    assign is_st  = opcode == OP_STORE;
    assign is_mem = is_st || opcode == OP_LOAD;

    lsu_ctrl_load_align u_align (
        .rdata   (data_q),
        .funct3  (f3_q),
        .addr_lo (al_q),
        .result  (aligned)
    );

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            cnt    <= '0;
            f3_q   <= '0;
            al_q   <= '0;
            we_q   <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && state_nx == ACCESS) begin
                f3_q <= funct3;
                al_q <= addr_lo;
                we_q <= is_st;
            end
            if (state == ACCESS && mem_ready && !we_q) data_q <= rdata;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_be   = 4'b0000;
        ld_regw  = 1'b0;
        fault    = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem && access_legal(is_st, funct3, addr_lo)) begin
                    stall    = 1'b1;
                    state_nx = ACCESS;
                end else if (is_mem) begin
                    fault = 1'b1;
                end
            end
            ACCESS: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                mem_be  = byte_en(f3_q[1:0], al_q);
                stall   = 1'b1;
                if (mem_ready) begin
                    // A store retires in its completion cycle; a load still needs WB.
                    stall    = !we_q;
                    cnt_nx   = '0;
                    state_nx = we_q ? IDLE : WB;
                end else if (cnt == MAX_W) begin
                    fault    = 1'b1;
                    stall    = 1'b0;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            WB: begin
                ld_regw  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Held opcode would otherwise re-raise stall while reset is asserted.
        if (!nReset) begin
            stall   = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            mem_be  = 4'b0000;
            ld_regw = 1'b0;
            fault   = 1'b0;
        end
    end

    assign ld_wdata = (state == WB && nReset) ? aligned : 32'h0;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store sequencer for the single-issue RISC-V core. It sits beside the instruction decoder: it recognises load and store opcodes and stalls PC increment while the access runs. It drives a ready/request handshake to data memory and returns aligned, sign/zero-extended load data with a one-cycle register-write strobe. Misaligned accesses, illegal load/store widths and memory timeouts raise a one-cycle fault.

## Interface
Parameters:
- MAX_WAIT, 15 — ACCESS cycles without mem_ready before timeout fault (1..255).

Ports:
- clock  in  1  system clock; all state updates on rising edge
- nReset  in  1  asynchronous, active-low reset
- opcode  in  7  instruction opcode; held stable by datapath while stall=1
- funct3  in  3  access width/sign field
- addr_lo  in  2  low bits of ALU effective address
- mem_ready  in  1  memory completes the access this cycle
- rdata  in  32  memory read word, valid when mem_ready=1
- stall  out  1  1 = hold PC (suppress incr)
- mem_req  out  1  access request
- mem_we  out  1  1 = store
- mem_be  out  4  byte enables
- ld_wdata  out  32  extended load result
- ld_regw  out  1  load result write strobe (one cycle)
- fault  out  1  one-cycle fault pulse

## Operation
- States: IDLE, ACCESS, WB. Reset → IDLE; all outputs 0, wait counter 0, captured data 0.
- IDLE: opcode ILOAD (0000011) or SSTORE (0100011) → legality check:
  - illegal funct3 (load: 011/110/111; store: ≥011) or misaligned (word: addr_lo≠00; half: addr_lo[0]=1) → fault=1 this cycle, stall=0, stay IDLE, no memory access.
  - otherwise stall=1, latch funct3, addr_lo, we → ACCESS.
  - any other opcode: all outputs 0.
- ACCESS: mem_req=1, mem_we=latched we, mem_be from latched funct3/addr_lo; stall=1 except in a store's completion cycle.
  - mem_ready=1, load: capture rdata → WB.
  - mem_ready=1, store: stall=0 this cycle (retires) → IDLE.
  - mem_ready=0: counter+1; on counter==MAX_WAIT: fault=1, mem_req still 1 that cycle, stall=0 → IDLE, counter cleared.
- WB: ld_regw=1, ld_wdata valid, stall=0 (retires) → IDLE.
- Byte enables: byte = 4'b0001<<addr_lo; half = 4'b0011<<addr_lo; word = 4'b1111.
- Load extend: select byte/half by latched addr_lo; lb/lh sign-extend, lbu/lhu zero-extend, lw pass through. ld_wdata is 0 outside WB.
- Store data alignment is the datapath's job, not this block's.

## Timing
- Load: min 3 cycles (detect, ACCESS with ready, WB). Store: min 2 cycles.
- Each mem_ready=0 cycle adds 1; max ACCESS length MAX_WAIT+1 cycles.
- stall is combinational from state and inputs; asserted in the detect cycle, so PC never advances past a pending access.
- mem_ready outside ACCESS is ignored.
- Reset mid-operation: mem_req, stall and ld_regw drop immediately (asynchronous). No partial write completes.
- Back-to-back memory instructions: IDLE after retire detects the next one the following cycle. There is no extra bubble.

## Structure
- Shared package: state enum typedef (IDLE/ACCESS/WB), load/store funct3 constants. Opcodes come from the existing opcodes include.
- One sub-module, load_align: combinational byte/half select and extension (rdata, funct3, addr_lo → 32-bit result).

## Test plan
- lw, addr_lo=00, mem_ready in first ACCESS cycle, rdata=32'hDEADBEEF → ld_regw=1 in cycle 2, ld_wdata=32'hDEADBEEF; stall=1 in cycles 0–1 only.
- lb, addr_lo=11, rdata=32'h80000000 → mem_be=4'b1000, ld_wdata=32'hFFFFFF80; lbu same → 32'h00000080.
- sh, addr_lo=10, mem_ready after 3 wait cycles → mem_we=1, mem_be=4'b1100 for 4 ACCESS cycles, stall=0 in the ready cycle, no ld_regw.
- lw, addr_lo=01 → fault pulse in detect cycle, mem_req never asserted, stall=0.
- MAX_WAIT=4, mem_ready held 0 → fault on 5th ACCESS cycle, return to IDLE, no ld_regw.
- nReset low during ACCESS → mem_req/stall 0 immediately; after release, IDLE and a new lw completes normally.
